// File: rtl/synth_pkg.sv
// Shared constants, sample type and helpers for the synth audio path.
package synth_pkg;

  localparam int unsigned AUDIO_WIDTH    = 32;
  localparam int unsigned NUM_VOICES     = 8;
  localparam int unsigned MIX_LATENCY    = 5;
  localparam int unsigned OUT_WIDTH      = 24;
  localparam int unsigned CLIP_CNT_WIDTH = 16;
  localparam int unsigned VOL_WIDTH      = 4;
  localparam int unsigned ACT_WIDTH      = 4;

  typedef logic signed [AUDIO_WIDTH-1:0] sample_t;

  // Number of gated voices in a note_on vector.
  function automatic logic [ACT_WIDTH-1:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [ACT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      n = n + ACT_WIDTH'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Registered saturation stage: clamps a wide signed value to SAT_W bits and
// keeps the top OUT_W bits of the clamped result, flagging any clamp.
module mix_saturate #(
  parameter int unsigned IN_W  = 35,
  parameter int unsigned SAT_W = 32,
  parameter int unsigned OUT_W = SAT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [IN_W-1:0]  data_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    clip_o,
  output logic                    clip_c
);

  localparam int unsigned EXT_W = IN_W - SAT_W;
  localparam logic signed [IN_W-1:0] MAX_V = {{(EXT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(EXT_W+1){1'b1}}, {(SAT_W-1){1'b0}}};

  logic                    hi_c;
  logic                    lo_c;
  logic signed [OUT_W-1:0] data_d;
  logic signed [OUT_W-1:0] data_q;
  logic                    valid_q;
  logic                    clip_q;

  // Range check and clamp; the in-range path truncates the low bits.
  always_comb begin
    hi_c   = (data_i > MAX_V);
    lo_c   = (data_i < MIN_V);
    clip_c = hi_c | lo_c;
    data_d = data_i[SAT_W-1 -: OUT_W];
    if (hi_c) begin
      data_d = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (lo_c) begin
      data_d = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // Output register: data holds between samples, valid and clip are pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      clip_q  <= valid_i & clip_c;
      if (valid_i) begin
        data_q <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign clip_o  = clip_q;
  assign data_o  = data_q;

endmodule

// File: rtl/voice_mixer.sv
// Eight-voice mono mixer: capture, three-level adder tree, volume shift,
// saturate. Also reports active voice count and clip statistics.
module voice_mixer
  import synth_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  sample_t                     voice_1_in,
  input  sample_t                     voice_2_in,
  input  sample_t                     voice_3_in,
  input  sample_t                     voice_4_in,
  input  sample_t                     voice_5_in,
  input  sample_t                     voice_6_in,
  input  sample_t                     voice_7_in,
  input  sample_t                     voice_8_in,
  input  logic [NUM_VOICES-1:0]       note_on,
  input  logic                        data_valid_in,
  input  logic [VOL_WIDTH-1:0]        volume,
  input  logic                        clip_clr,
  output logic signed [OUT_WIDTH-1:0] mix_out,
  output logic                        mix_valid,
  output logic                        clip,
  output logic [CLIP_CNT_WIDTH-1:0]   clip_count,
  output logic [ACT_WIDTH-1:0]        active_count
);

  localparam int unsigned S1_W = AUDIO_WIDTH + 1;
  localparam int unsigned S2_W = AUDIO_WIDTH + 2;
  localparam int unsigned S3_W = AUDIO_WIDTH + 3;
  localparam int unsigned S1_N = NUM_VOICES / 2;
  localparam int unsigned S2_N = NUM_VOICES / 4;

  sample_t                  voice_c [NUM_VOICES];
  sample_t                  voice_q [NUM_VOICES];
  logic [VOL_WIDTH-1:0]     vol0_q, vol1_q, vol2_q, vol3_q;
  logic                     v0_q, v1_q, v2_q, v3_q;
  logic [ACT_WIDTH-1:0]     act_q;
  logic signed [S1_W-1:0]   sum1_d [S1_N];
  logic signed [S1_W-1:0]   sum1_q [S1_N];
  logic signed [S2_W-1:0]   sum2_d [S2_N];
  logic signed [S2_W-1:0]   sum2_q [S2_N];
  logic signed [S3_W-1:0]   sum3_d;
  logic signed [S3_W-1:0]   sum3_q;
  logic signed [S3_W-1:0]   shifted_c;
  logic                     sat_clip_c;
  logic [CLIP_CNT_WIDTH-1:0] clip_cnt_d;
  logic [CLIP_CNT_WIDTH-1:0] clip_cnt_q;

  // Gather the voice ports into an array for the tree.
  always_comb begin
    voice_c[0] = voice_1_in;
    voice_c[1] = voice_2_in;
    voice_c[2] = voice_3_in;
    voice_c[3] = voice_4_in;
    voice_c[4] = voice_5_in;
    voice_c[5] = voice_6_in;
    voice_c[6] = voice_7_in;
    voice_c[7] = voice_8_in;
  end

  // S0: capture voices, volume and voice count with the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        voice_q[i] <= '0;
      end
      vol0_q <= '0;
      v0_q   <= 1'b0;
      act_q  <= '0;
    end else begin
      v0_q <= data_valid_in;
      if (data_valid_in) begin
        voice_q <= voice_c;
        vol0_q  <= volume;
        act_q   <= popcount(note_on);
      end
    end
  end

  // Adder tree next-state: each level grows one bit, so no level can overflow.
  always_comb begin
    for (int i = 0; i < int'(S1_N); i++) begin
      sum1_d[i] = S1_W'(voice_q[2*i]) + S1_W'(voice_q[2*i+1]);
    end
    for (int i = 0; i < int'(S2_N); i++) begin
      sum2_d[i] = S2_W'(sum1_q[2*i]) + S2_W'(sum1_q[2*i+1]);
    end
    sum3_d = S3_W'(sum2_q[0]) + S3_W'(sum2_q[1]);
  end

  // S1..S3 registers; each level loads only behind a valid sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(S1_N); i++) begin
        sum1_q[i] <= '0;
      end
      for (int i = 0; i < int'(S2_N); i++) begin
        sum2_q[i] <= '0;
      end
      sum3_q <= '0;
      vol1_q <= '0;
      vol2_q <= '0;
      vol3_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v0_q) begin
        sum1_q <= sum1_d;
        vol1_q <= vol0_q;
      end
      if (v1_q) begin
        sum2_q <= sum2_d;
        vol2_q <= vol1_q;
      end
      if (v2_q) begin
        sum3_q <= sum3_d;
        vol3_q <= vol2_q;
      end
    end
  end

  // S4: volume attenuation, arithmetic shift rounds toward minus infinity.
  assign shifted_c = sum3_q >>> vol3_q;

  // S5: clamp to the voice sample range and keep the top output bits.
  mix_saturate #(
    .IN_W  (S3_W),
    .SAT_W (AUDIO_WIDTH),
    .OUT_W (OUT_WIDTH)
  ) u_sat (
    .clk     (clk),
    .rst     (rst),
    .valid_i (v3_q),
    .data_i  (shifted_c),
    .valid_o (mix_valid),
    .data_o  (mix_out),
    .clip_o  (clip),
    .clip_c  (sat_clip_c)
  );

  // Clip counter next-state: clear has priority, count saturates at all-ones.
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (clip_clr) begin
      clip_cnt_d = '0;
    end else if (v3_q && sat_clip_c && !(&clip_cnt_q)) begin
      clip_cnt_d = clip_cnt_q + CLIP_CNT_WIDTH'(1);
    end
  end

  // Clip counter register, updated on the same edge that presents the clip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_count   = clip_cnt_q;
  assign active_count = act_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed and randomized checks of voice_mixer against an arithmetic model.
module tb_voice_mixer;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [31:0] vin [8];
  logic [7:0]        note_on;
  logic              data_valid_in;
  logic [3:0]        volume;
  logic              clip_clr;
  logic [23:0]       mix_out;
  logic              mix_valid;
  logic              clip;
  logic [15:0]       clip_count;
  logic [3:0]        active_count;

  int vectors    = 0;
  int miscompares = 0;
  int ecnt       = 0;

  typedef struct {
    int          due;
    logic [23:0] out;
    logic        clp;
  } exp_t;

  exp_t        q[$];
  logic [23:0] m_out   = '0;
  logic        m_valid = 1'b0;
  logic        m_clip  = 1'b0;
  logic [15:0] m_cnt   = '0;
  logic [3:0]  m_act   = '0;

  always #5 clk = ~clk;

  voice_mixer dut (
    .clk           (clk),
    .rst           (rst),
    .voice_1_in    (vin[0]),
    .voice_2_in    (vin[1]),
    .voice_3_in    (vin[2]),
    .voice_4_in    (vin[3]),
    .voice_5_in    (vin[4]),
    .voice_6_in    (vin[5]),
    .voice_7_in    (vin[6]),
    .voice_8_in    (vin[7]),
    .note_on       (note_on),
    .data_valid_in (data_valid_in),
    .volume        (volume),
    .clip_clr      (clip_clr),
    .mix_out       (mix_out),
    .mix_valid     (mix_valid),
    .clip          (clip),
    .clip_count    (clip_count),
    .active_count  (active_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, floor shift, clamp, keep bits 31..8.
  function automatic exp_t ref_mix(input int due);
    exp_t   r;
    longint s;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'(vin[i]);
    s = s >>> volume;
    r.due = due;
    r.clp = (s > SMAX) || (s < SMIN);
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    r.out = s[31:8];
    return r;
  endfunction

  // Scoreboard: model the observable outputs every clock and compare.
  always @(posedge clk) begin
    ecnt++;
    if (rst) begin
      q.delete();
      m_out = '0; m_valid = 1'b0; m_clip = 1'b0; m_cnt = '0; m_act = '0;
    end else begin
      m_valid = 1'b0;
      m_clip  = 1'b0;
      if (q.size() > 0 && q[0].due == ecnt) begin
        m_valid = 1'b1;
        m_out   = q[0].out;
        m_clip  = q[0].clp;
        void'(q.pop_front());
      end
      if (clip_clr) m_cnt = '0;
      else if (m_clip && m_cnt != 16'hFFFF) m_cnt++;
      if (data_valid_in) begin
        q.push_back(ref_mix(ecnt + 4));
        m_act = 4'($countones(note_on));
      end
    end
    #2;
    chk("mon_valid", {31'b0, mix_valid}, {31'b0, m_valid});
    chk("mon_mix_out", {8'b0, mix_out}, {8'b0, m_out});
    chk("mon_clip", {31'b0, clip}, {31'b0, m_clip});
    chk("mon_clip_count", {16'b0, clip_count}, {16'b0, m_cnt});
    chk("mon_active", {28'b0, active_count}, {28'b0, m_act});
  end

  task automatic set_all(input logic signed [31:0] v);
    for (int i = 0; i < 8; i++) vin[i] = v;
  endtask

  // Wait (bounded) for the next mix_valid, sampled after the edge.
  task automatic wait_mix(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (mix_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  initial begin
    bit got;
    set_all('0);
    note_on = '0; data_valid_in = 1'b0; volume = '0; clip_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mix_out", {8'b0, mix_out}, 32'd0);
    chk("rst_valid", {31'b0, mix_valid}, 32'd0);
    chk("rst_clip", {31'b0, clip}, 32'd0);
    chk("rst_clip_count", {16'b0, clip_count}, 32'd0);
    chk("rst_active", {28'b0, active_count}, 32'd0);
    rst = 1'b0;

    // Positive overflow clips to full scale.
    @(negedge clk); set_all(32'sh1000_0000); volume = 4'd0; note_on = 8'hFF; data_valid_in = 1'b1;
    @(negedge clk); data_valid_in = 1'b0;
    wait_mix("t1_wait", got);
    chk("t1_mix_out", {8'b0, mix_out}, 32'h007F_FFFF);
    chk("t1_clip", {31'b0, clip}, 32'd1);
    chk("t1_clip_count", {16'b0, clip_count}, 32'd1);

    // Halved gain brings the same sum into range.
    @(negedge clk); volume = 4'd1; data_valid_in = 1'b1;
    @(negedge clk); data_valid_in = 1'b0;
    wait_mix("t2_wait", got);
    chk("t2_mix_out", {8'b0, mix_out}, 32'h0040_0000);
    chk("t2_clip", {31'b0, clip}, 32'd0);

    // Exact negative full scale is not a clip.
    @(negedge clk); set_all(-32'sh1000_0000); volume = 4'd0; data_valid_in = 1'b1;
    @(negedge clk); data_valid_in = 1'b0;
    wait_mix("t3a_wait", got);
    chk("t3a_mix_out", {8'b0, mix_out}, 32'h0080_0000);
    chk("t3a_clip", {31'b0, clip}, 32'd0);

    // Floor rounding of -1 under attenuation.
    @(negedge clk); set_all('0); vin[0] = -32'sd1; volume = 4'd4; data_valid_in = 1'b1;
    @(negedge clk); data_valid_in = 1'b0;
    wait_mix("t3b_wait", got);
    chk("t3b_mix_out", {8'b0, mix_out}, 32'h00FF_FFFF);

    // Back-to-back samples emerge in order on consecutive cycles.
    volume = 4'd0;
    fork
      begin
        for (int k = 1; k <= 10; k++) begin
          @(negedge clk); set_all('0); vin[0] = 32'(k * 256); data_valid_in = 1'b1;
        end
        @(negedge clk); data_valid_in = 1'b0;
      end
      begin
        bit g4;
        wait_mix("t4_wait", g4);
        if (g4) begin
          for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin
              @(posedge clk); #3;
            end
            chk("t4_valid", {31'b0, mix_valid}, 32'd1);
            chk("t4_mix_out", {8'b0, mix_out}, 32'(k));
          end
        end
      end
    join

    // Active voice count one cycle after capture.
    @(negedge clk); set_all('0); note_on = 8'b1011_0001; data_valid_in = 1'b1;
    @(posedge clk); #3;
    chk("t5_active", {28'b0, active_count}, 32'd4);
    @(negedge clk); data_valid_in = 1'b0;

    // Drive the clip counter to saturation.
    set_all(32'sh1000_0000); volume = 4'd0;
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk); data_valid_in = 1'b1; note_on = 8'($urandom);
    end
    @(negedge clk); data_valid_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_clip_sat", {16'b0, clip_count}, 32'h0000_FFFF);

    // Clear arriving on the same edge as a clipped sample wins.
    @(negedge clk); data_valid_in = 1'b1;
    @(negedge clk); data_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    clip_clr = 1'b1;
    @(posedge clk); #3;
    chk("t5_clr_clip", {31'b0, clip}, 32'd1);
    chk("t5_clr_count", {16'b0, clip_count}, 32'd0);
    @(negedge clk); clip_clr = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) vin[i] = $signed($urandom) >>> $urandom_range(0, 5);
      volume        = 4'($urandom_range(0, 15));
      note_on       = 8'($urandom);
      data_valid_in = ($urandom_range(0, 9) < 7);
      clip_clr      = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk); data_valid_in = 1'b0; clip_clr = 1'b0;
    repeat (8) @(negedge clk);

    // Reset while three samples are in flight discards them.
    set_all(32'sh0123_4567); volume = 4'd0; note_on = 8'h0F;
    repeat (3) begin
      @(negedge clk); data_valid_in = 1'b1;
    end
    @(negedge clk); data_valid_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("t6_rst_mix_out", {8'b0, mix_out}, 32'd0);
    chk("t6_rst_valid", {31'b0, mix_valid}, 32'd0);
    chk("t6_rst_clip_count", {16'b0, clip_count}, 32'd0);
    chk("t6_rst_active", {28'b0, active_count}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_valid", {31'b0, mix_valid}, 32'd0);
    end
    chk("t6_mix_out", {8'b0, mix_out}, 32'd0);
    chk("t6_active", {28'b0, active_count}, 32'd0);

    // First post-reset sample flows normally.
    @(negedge clk); set_all('0); vin[2] = 32'sh0000_0500; data_valid_in = 1'b1;
    @(negedge clk); data_valid_in = 1'b0;
    wait_mix("t6_post_wait", got);
    chk("t6_post_mix_out", {8'b0, mix_out}, 32'h0000_0005);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
